spi_reg_ctrl: RTL
=================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on sck/sdi/nss.
REQ-002 Port: clk  in  1  system clock (HSOSC, 24 MHz); all state is clocked on posedge clk.
REQ-003 Port: rst  in  1  reset, synchronous, active-low.
REQ-004 Port: sck  in  1  SPI clock from master, asynchronous to clk; mode 0 (CPOL=0, CPHA=0).
REQ-005 Port: sdi  in  1  SPI data in, MSB first.
REQ-006 Port: nss  in  1  SPI slave select, active-low, asynchronous.
REQ-007 Port: sdo  out  1  SPI data out, MSB first.
REQ-008 Port: regs  out  32  register bank {reg3,reg2,reg1,reg0}; reg0 occupies bits [7:0].
REQ-009 Port: wr_stb  out  1  one-cycle pulse on each register commit.
REQ-010 Port: wr_addr  out  2  address of the last commit; valid while wr_stb=1.
REQ-011 Port: frame_err  out  1  one-cycle pulse when a frame aborts early.
REQ-012 Port: busy  out  1  high while the FSM is not in IDLE.

Function
REQ-013 sck, sdi and nss SHALL each pass through SYNC_STAGES flops; sck edges SHALL be detected from the last two synchronized samples.
REQ-014 Master sck frequency SHALL be at most clk/8; no behaviour is defined above that rate.
REQ-015 A frame SHALL be nss low, then a command byte, then a data byte; sdi SHALL be sampled on the detected sck rising edge and shifted in MSB first.
REQ-016 Command byte fields: bit7 = 1 for read, 0 for write; bits[1:0] = address; bits[6:2] ignored.
REQ-017 FSM states: IDLE, CMD, DATA, HOLD.
REQ-018 IDLE -> CMD on synchronized nss falling; the bit counter SHALL clear to 0.
REQ-019 CMD -> DATA on the 8th rising edge; cmd SHALL latch; on a read, tx_shift SHALL load regs[addr] in the same cycle.
REQ-020 DATA -> HOLD on the 8th rising edge; on a write, regs[addr] SHALL take the received byte and wr_stb=1 with wr_addr=addr in the following cycle.
REQ-021 In HOLD, sck edges SHALL be ignored; nss high SHALL move HOLD -> IDLE.
REQ-022 Synchronized nss high in CMD or DATA SHALL abort to IDLE: no register write, frame_err=1 for one cycle.
REQ-023 In CMD, sdo SHALL be 0.
REQ-024 In DATA on a read, sdo SHALL equal tx_shift[7]; tx_shift SHALL shift left on each detected sck falling edge, after the first falling edge of DATA.
REQ-025 In IDLE and HOLD, and during write DATA, sdo SHALL be 0.
REQ-026 A synchronized nss falling edge seen outside IDLE SHALL be ignored.
REQ-027 sck edges while nss is high SHALL have no effect.
REQ-028 Read latency: the sdo MSB SHALL be valid at most SYNC_STAGES+2 clk cycles after the 8th command rising edge.
REQ-029 Write latency: wr_stb SHALL assert SYNC_STAGES+2 clk cycles after the 16th sck rising edge at the pin.
REQ-030 The counter SHALL be 3 bits wide and wrap 7 -> 0 at each byte boundary.
REQ-031 A read SHALL NOT modify regs.

Reset
REQ-032 While rst=0 at posedge clk: state=IDLE, counters=0, regs=32'h0, tx_shift=0, sdo=0, wr_stb=0, frame_err=0, busy=0.
REQ-033 Reset asserted mid-frame SHALL discard the frame; after release, the controller SHALL wait for a fresh nss falling edge and SHALL NOT pulse frame_err.
REQ-034 Synchronizer flops SHALL also clear to the idle bus level: nss=1, sck=0.

Verification
REQ-035 Write 0x02 then 0xA5 at sck=clk/8 -> regs[23:16]=0xA5, one wr_stb with wr_addr=2, other registers unchanged.
REQ-036 After REQ-035, read 0x82 then dummy 0x00 -> sdo shifts out 1010_0101 on the data byte, regs unchanged, no wr_stb.
REQ-037 Write 0x01, then nss high after 5 data bits -> frame_err one cycle, regs[15:8] stays 0x00, busy=0.
REQ-038 Write 0x00/0x3C followed by 8 extra sck pulses before nss high -> reg0=0x3C, exactly one wr_stb, extra clocks ignored.
REQ-039 rst=0 asserted during the 4th bit of a data byte -> all outputs take reset values; the next complete write to addr 3 with 0x7E commits normally.
REQ-040 Command 0x7D (bits[6:2] set, addr 1) then 0x11 -> treated as write to addr 1, reg1=0x11.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave exposing a four-byte register bank.
// Frame: nss low, command byte {rd,xxxxx,addr}, data byte.
module spi_reg_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        sdi,
  input  logic        nss,
  output logic        sdo,
  output logic [31:0] regs,
  output logic        wr_stb,
  output logic [1:0]  wr_addr,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sy, sdi_sy, nss_sy, fill;
  logic                   sck_d, nss_d, armed;
  logic [2:0]             cnt;
  logic [6:0]             rx;
  logic                   cmd_rd, first_fall, wr_pend;
  logic [1:0]             cmd_addr;
  logic [7:0]             tx_shift;

  logic sck_s, sdi_s, nss_s, rise, fall, nss_fall;

  assign sck_s    = sck_sy[SYNC_STAGES-1];
  assign sdi_s    = sdi_sy[SYNC_STAGES-1];
  assign nss_s    = nss_sy[SYNC_STAGES-1];
  assign rise     = sck_s & ~sck_d;
  assign fall     = ~sck_s & sck_d;
  // armed blocks a false falling edge when nss is already low at reset release
  assign nss_fall = armed & nss_d & ~nss_s;
  assign sdo      = tx_shift[7];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_sy     <= '0;
      sdi_sy     <= '0;
      nss_sy     <= '1;
      fill       <= '0;
      sck_d      <= 1'b0;
      nss_d      <= 1'b1;
      armed      <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      rx         <= '0;
      cmd_rd     <= 1'b0;
      cmd_addr   <= '0;
      first_fall <= 1'b0;
      tx_shift   <= '0;
      regs       <= '0;
      wr_pend    <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sck_sy[0] <= sck;
      sdi_sy[0] <= sdi;
      nss_sy[0] <= nss;
      fill[0]   <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sy[i] <= sck_sy[i-1];
        sdi_sy[i] <= sdi_sy[i-1];
        nss_sy[i] <= nss_sy[i-1];
        fill[i]   <= fill[i-1];
      end
      sck_d <= sck_s;
      nss_d <= nss_s;
      if (fill[SYNC_STAGES-1] && nss_s) armed <= 1'b1;

      frame_err <= 1'b0;
      wr_pend   <= 1'b0;
      wr_stb    <= wr_pend;

      unique case (state)
        IDLE: begin
          if (nss_fall) begin
            state <= CMD;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CMD: begin
          if (nss_s) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end else if (rise) begin
            rx  <= {rx[5:0], sdi_s};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state      <= DATA;
              cmd_rd     <= rx[6];
              cmd_addr   <= {rx[0], sdi_s};
              first_fall <= 1'b1;
              if (rx[6])
                tx_shift <= regs[{rx[0], sdi_s, 3'b000} +: 8];
            end
          end
        end
        DATA: begin
          if (nss_s) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            tx_shift  <= '0;
          end else if (fall) begin
            // the first fall closes the command byte; MSB is already out
            if (first_fall) first_fall <= 1'b0;
            else            tx_shift   <= {tx_shift[6:0], 1'b0};
          end else if (rise) begin
            rx  <= {rx[5:0], sdi_s};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state    <= HOLD;
              tx_shift <= '0;
              if (!cmd_rd) begin
                regs[{cmd_addr, 3'b000} +: 8] <= {rx, sdi_s};
                wr_addr <= cmd_addr;
                wr_pend <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (nss_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
